// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID-stage pipeline control and hazard_ctrl: decoded ID
// fields and pipeline events in, forwarding codes and sequencing controls out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_is_load;
    logic             ex_branch_taken;
    logic             mem_busy;

    logic             is_hazard1;
    logic [2:0]       hazard_reg1;
    logic             is_hazard2;
    logic [2:0]       hazard_reg2;
    logic             stall;
    logic             flush;
    logic             freeze;
    logic             wait_state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_is_load, ex_branch_taken, mem_busy,
        input  is_hazard1, hazard_reg1, is_hazard2, hazard_reg2,
               stall, flush, freeze, wait_state, stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_is_load, ex_branch_taken, mem_busy,
        output is_hazard1, hazard_reg1, is_hazard2, hazard_reg2,
               stall, flush, freeze, wait_state, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection and pipeline sequencing for the 5-stage RV32I core: shadows
// the EX/MEM destination registers, emits forwarding codes and stall/flush/freeze.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Shadow slots {v, rd, ld} for the instructions currently in EX and MEM
    logic             ex_v_q,  ex_v_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic             ex_ld_q, ex_ld_d;
    logic             mem_v_q,  mem_v_d;
    logic [4:0]       mem_rd_q, mem_rd_d;
    logic             mem_ld_q, mem_ld_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       ex_m1_s, ex_m2_s, mem_m1_s, mem_m2_s;
    logic       ld_use_s;
    logic [2:0] code1_s, code2_s;
    logic       stall_s, flush_s, freeze_s;

    function automatic logic slot_match(input logic v, input logic [4:0] rd,
                                        input logic [4:0] src);
        return v && (rd != 5'd0) && (rd == src);
    endfunction

    // Source matches against both slots and the forwarding codes
    always_comb begin
        ex_m1_s  = bus.id_use_rs1 && slot_match(ex_v_q,  ex_rd_q,  bus.id_rs1);
        ex_m2_s  = bus.id_use_rs2 && slot_match(ex_v_q,  ex_rd_q,  bus.id_rs2);
        mem_m1_s = bus.id_use_rs1 && slot_match(mem_v_q, mem_rd_q, bus.id_rs1);
        mem_m2_s = bus.id_use_rs2 && slot_match(mem_v_q, mem_rd_q, bus.id_rs2);
        ld_use_s = bus.id_valid && ex_ld_q && (ex_m1_s || ex_m2_s);

        // A load in EX has no data yet, so it never yields an EX-distance code
        if (!bus.id_valid || ld_use_s) begin
            code1_s = 3'd0;
        end else if (ex_m1_s) begin
            code1_s = 3'd1;
        end else if (ex_m2_s) begin
            code1_s = 3'd2;
        end else begin
            code1_s = 3'd0;
        end

        if (!bus.id_valid) begin
            code2_s = 3'd0;
        end else if (mem_m1_s) begin
            code2_s = 3'd3;
        end else if (mem_m2_s) begin
            code2_s = 3'd4;
        end else begin
            code2_s = 3'd0;
        end
    end

    // Per-cycle control priority: memory wait, then branch flush, then load-use
    always_comb begin
        freeze_s = !reset && bus.mem_busy;
        flush_s  = !reset && !bus.mem_busy && bus.ex_branch_taken;
        stall_s  = !reset && (bus.mem_busy ||
                              (!bus.ex_branch_taken && ld_use_s));
    end

    // Next-state for shadow slots, FSM and counters
    always_comb begin
        ex_v_d      = ex_v_q;
        ex_rd_d     = ex_rd_q;
        ex_ld_d     = ex_ld_q;
        mem_v_d     = mem_v_q;
        mem_rd_d    = mem_rd_q;
        mem_ld_d    = mem_ld_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (bus.mem_busy) begin
            ex_v_d = ex_v_q;
        end else if (bus.ex_branch_taken || ld_use_s) begin
            mem_v_d  = ex_v_q;
            mem_rd_d = ex_rd_q;
            mem_ld_d = ex_ld_q;
            ex_v_d   = 1'b0;
            ex_rd_d  = 5'd0;
            ex_ld_d  = 1'b0;
        end else begin
            mem_v_d  = ex_v_q;
            mem_rd_d = ex_rd_q;
            mem_ld_d = ex_ld_q;
            ex_v_d   = bus.id_valid && bus.id_regwrite;
            ex_rd_d  = bus.id_rd;
            ex_ld_d  = bus.id_valid && bus.id_is_load;
        end

        if ((stall_s || freeze_s) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end

        case (state_q)
            ST_RUN:  state_d = bus.mem_busy ? ST_WAIT : ST_RUN;
            ST_WAIT: state_d = bus.mem_busy ? ST_WAIT : ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v_q      <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_ld_q     <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_ld_q    <= 1'b0;
            state_q     <= ST_RUN;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rd_q     <= ex_rd_d;
            ex_ld_q     <= ex_ld_d;
            mem_v_q     <= mem_v_d;
            mem_rd_q    <= mem_rd_d;
            mem_ld_q    <= mem_ld_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.is_hazard1   = (code1_s != 3'd0);
    assign bus.hazard_reg1  = code1_s;
    assign bus.is_hazard2   = (code2_s != 3'd0);
    assign bus.hazard_reg2  = code2_s;
    assign bus.stall        = stall_s;
    assign bus.flush        = flush_s;
    assign bus.freeze       = freeze_s;
    assign bus.wait_state   = (state_q == ST_WAIT);
    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: each driven cycle pushes its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;
    logic clk;
    logic reset;

    hazard_ctrl_if #(.CNT_W(16)) bus ();

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      nm;
        logic       hz1;
        logic [2:0] hr1;
        logic       hz2;
        logic [2:0] hr2;
        logic       st;
        logic       fl;
        logic       fr;
        logic       ws;
        int         sc;
        int         fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: one expected entry per driven cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.nm, "is_hazard1",   32'(bus.is_hazard1),   32'(e.hz1));
                cmp(e.nm, "hazard_reg1",  32'(bus.hazard_reg1),  32'(e.hr1));
                cmp(e.nm, "is_hazard2",   32'(bus.is_hazard2),   32'(e.hz2));
                cmp(e.nm, "hazard_reg2",  32'(bus.hazard_reg2),  32'(e.hr2));
                cmp(e.nm, "stall",        32'(bus.stall),        32'(e.st));
                cmp(e.nm, "flush",        32'(bus.flush),        32'(e.fl));
                cmp(e.nm, "freeze",       32'(bus.freeze),       32'(e.fr));
                cmp(e.nm, "wait_state",   32'(bus.wait_state),   32'(e.ws));
                cmp(e.nm, "stall_cycles", 32'(bus.stall_cycles), 32'(e.sc));
                cmp(e.nm, "flush_count",  32'(bus.flush_count),  32'(e.fc));
            end
        end
    end

    task automatic d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic ld, input logic br,
                     input logic busy, input logic rst);
        @(posedge clk);
        #1;
        bus.id_valid        = v;
        bus.id_rs1          = rs1;
        bus.id_rs2          = rs2;
        bus.id_use_rs1      = u1;
        bus.id_use_rs2      = u2;
        bus.id_rd           = rd;
        bus.id_regwrite     = rw;
        bus.id_is_load      = ld;
        bus.ex_branch_taken = br;
        bus.mem_busy        = busy;
        reset               = rst;
    endtask

    task automatic e(input string nm, input logic hz1, input logic [2:0] hr1,
                     input logic hz2, input logic [2:0] hr2, input logic st,
                     input logic fl, input logic fr, input logic ws,
                     input int sc, input int fc);
        exp_t x;
        x.nm = nm; x.hz1 = hz1; x.hr1 = hr1; x.hz2 = hz2; x.hr2 = hr2;
        x.st = st; x.fl = fl; x.fr = fr; x.ws = ws; x.sc = sc; x.fc = fc;
        exp_q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.id_valid = 1'b0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.id_rd = 5'd0;
        bus.id_regwrite = 1'b0; bus.id_is_load = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.mem_busy = 1'b0;

        //  v  rs1    rs2    u1    u2    rd     rw    ld    br    busy  rst
        d(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e("reset",          1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("add_x5",         1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd5,  5'd3,  1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("sub_ex_fwd",     1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("addi_x7",        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("nop",            1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd1,  5'd7,  1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("or_mem_fwd",     1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        e("lw_x9",          1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd9,  5'd9,  1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("load_use_stall", 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd9,  5'd9,  1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("load_use_fwd",   1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        d(1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("addi_x0",        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        d(1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("read_x0",        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        d(1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("addi_x5",        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        d(1'b1, 5'd5,  5'd5,  1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("lui_stale",      1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        d(1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        e("lw_x13",         1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        d(1'b1, 5'd13, 5'd2,  1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        e("br_vs_load_use", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
        d(1'b1, 5'd13, 5'd13, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("post_flush",     1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
        d(1'b1, 5'd15, 5'd2,  1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        e("busy1",          1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1);
        d(1'b1, 5'd15, 5'd2,  1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        e("busy2",          1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1);
        d(1'b1, 5'd15, 5'd2,  1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        e("busy3_br",       1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1);
        d(1'b1, 5'd15, 5'd2,  1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        e("wait_exit_flush",1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 1);
        d(1'b1, 5'd15, 5'd16, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("after_wait",     1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4, 2);
        d(1'b1, 5'd17, 5'd17, 1'b1, 1'b1, 5'd18, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        e("busy_a",         1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 2);
        d(1'b1, 5'd17, 5'd17, 1'b1, 1'b1, 5'd18, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        e("busy_reset",     1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 2);
        d(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("post_reset",     1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("add_x20",        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b0, 5'd20, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("id_invalid",     1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd20, 5'd0,  1'b1, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("mem_fwd_rs1",    1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd1,  5'd21, 1'b1, 1'b1, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("ex_fwd_rs2",     1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b1, 5'd21, 5'd0,  1'b1, 1'b0, 5'd22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e("ex_and_mem",     1'b1, 3'd1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        d(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("idle",           1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
